// File: rtl/char2num_if.sv
// Byte-in / result-out handshake bundle for the ASCII decimal parser.
// The parser takes the slave view; whoever feeds bytes and consumes results takes the master view.
interface char2num_if #(
  parameter int W = 10
);
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] num;
  logic         neg;
  logic         err;
  logic [1:0]   err_code;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_valid, num, neg, err, err_code
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_valid, num, neg, err, err_code
  );
endinterface

// File: rtl/char2num.sv
// Serial ASCII-to-signed-decimal parser: one byte per accepted handshake,
// one result (magnitude, sign, error code) per delimiter-terminated token.
module char2num #(
  parameter int W          = 10,
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  char2num_if.slave   bus
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [1:0] {IDLE, SIGN, DIGIT, FLUSH} state_t;
  typedef enum logic [1:0] {CLS_DIGIT, CLS_SIGN, CLS_DELIM, CLS_OTHER} cls_t;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_BAD   = 2'd1;
  localparam logic [1:0] CODE_OVF   = 2'd2;
  localparam logic [1:0] CODE_NODIG = 2'd3;

  state_t         state, state_n;
  logic [W-1:0]   acc, acc_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           neg_r, neg_n;
  logic [1:0]     code_r, code_n;

  logic           out_valid_r;
  logic [W-1:0]   num_r;
  logic           neg_o, err_o;
  logic [1:0]     code_o;

  logic           emit;
  logic [W-1:0]   emit_num;
  logic           emit_neg;
  logic [1:0]     emit_code;

  cls_t           cls;
  logic           accept;
  logic [3:0]     digit;
  logic [W+3:0]   acc_ext, prod;
  logic           overflow;

  assign bus.in_ready  = !out_valid_r;
  assign bus.out_valid = out_valid_r;
  assign bus.num       = num_r;
  assign bus.neg       = neg_o;
  assign bus.err       = err_o;
  assign bus.err_code  = code_o;

  assign accept = bus.in_valid && !out_valid_r;
  assign digit  = bus.in_data[3:0];

  // Four extra bits hold acc*10+9 for any acc, so the range test never sees a wrapped value.
  assign acc_ext  = {4'b0000, acc};
  assign prod     = (acc_ext << 3) + (acc_ext << 1) + {{W{1'b0}}, digit};
  assign overflow = |prod[W+3:W];

  always_comb begin
    case (bus.in_data)
      8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
      8'h35, 8'h36, 8'h37, 8'h38, 8'h39: cls = CLS_DIGIT;
      8'h2D, 8'h2B:                      cls = CLS_SIGN;
      8'h20, 8'h0D, 8'h0A, 8'h2C:        cls = CLS_DELIM;
      default:                           cls = CLS_OTHER;
    endcase
  end

  always_comb begin
    // NOTE: every value written here gets a default first, so no path can infer a latch.
    state_n   = state;
    acc_n     = acc;
    cnt_n     = cnt;
    neg_n     = neg_r;
    code_n    = code_r;
    emit      = 1'b0;
    emit_num  = '0;
    emit_neg  = 1'b0;
    emit_code = CODE_NONE;

    if (accept) begin
      unique case (state)
        IDLE: begin
          if (cls == CLS_SIGN) begin
            neg_n   = (bus.in_data == 8'h2D);
            state_n = SIGN;
          end else if (cls == CLS_DIGIT) begin
            acc_n   = W'(digit);
            cnt_n   = CW'(1);
            neg_n   = 1'b0;
            state_n = DIGIT;
          end else if (cls == CLS_OTHER) begin
            code_n  = CODE_BAD;
            state_n = FLUSH;
          end
        end
        SIGN: begin
          if (cls == CLS_DIGIT) begin
            acc_n   = W'(digit);
            cnt_n   = CW'(1);
            state_n = DIGIT;
          end else if (cls == CLS_DELIM) begin
            emit      = 1'b1;
            emit_code = CODE_NODIG;
            state_n   = IDLE;
          end else begin
            code_n  = CODE_BAD;
            state_n = FLUSH;
          end
        end
        DIGIT: begin
          if (cls == CLS_DIGIT) begin
            if (cnt == CW'(MAX_DIGITS) || overflow) begin
              code_n  = CODE_OVF;
              state_n = FLUSH;
            end else begin
              acc_n = prod[W-1:0];
              cnt_n = cnt + CW'(1);
            end
          end else if (cls == CLS_DELIM) begin
            emit     = 1'b1;
            emit_num = acc;
            emit_neg = neg_r;
            state_n  = IDLE;
          end else begin
            code_n  = CODE_BAD;
            state_n = FLUSH;
          end
        end
        FLUSH: begin
          // code_r is left alone here so the first error in the token is the one reported.
          if (cls == CLS_DELIM) begin
            emit      = 1'b1;
            emit_code = code_r;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (emit) begin
      acc_n  = '0;
      cnt_n  = '0;
      neg_n  = 1'b0;
      code_n = CODE_NONE;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      neg_r       <= 1'b0;
      code_r      <= CODE_NONE;
      out_valid_r <= 1'b0;
      num_r       <= '0;
      neg_o       <= 1'b0;
      err_o       <= 1'b0;
      code_o      <= CODE_NONE;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      neg_r  <= neg_n;
      code_r <= code_n;
      // A new result can only be produced while no result is pending, so these never collide.
      if (emit) begin
        out_valid_r <= 1'b1;
        num_r       <= emit_num;
        neg_o       <= emit_neg;
        err_o       <= (emit_code != CODE_NONE);
        code_o      <= emit_code;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_char2num.sv
// Directed bench for char2num: byte strings in, results captured by a negedge
// monitor and compared against hand-computed values.
module tb_char2num;
  typedef struct packed {
    logic [9:0] num;
    logic       neg;
    logic       err;
    logic [1:0] code;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   last_acc = 0;
  int   valid_cycles = 0;
  int   first_valid  = -1;
  int   ready_low    = 0;
  res_t q[$];

  char2num_if #(.W(10)) bus ();

  char2num #(.W(10), .MAX_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      valid_cycles++;
      if (first_valid < 0) first_valid = cyc;
    end
    if (!bus.in_ready) ready_low++;
    if (bus.out_valid && bus.out_ready)
      q.push_back({bus.num, bus.neg, bus.err, bus.err_code});
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      else if (n >= 50) begin
        check("send_timeout", n < 50, 1);
        done = 1;
      end
      n++;
      @(posedge clk);
      #1;
    end
    last_acc = cyc;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    q.delete();
    valid_cycles = 0;
    first_valid  = -1;
    ready_low    = 0;
  endtask

  task automatic check_res(input string tag, input logic [9:0] n, input logic ng,
                           input logic e, input logic [1:0] c);
    res_t r;
    check({tag, "_avail"}, q.size() > 0, 1);
    if (q.size() > 0) begin
      r = q.pop_front();
      check(tag, r, {n, ng, e, c});
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_outputs", {bus.num, bus.neg, bus.err, bus.err_code}, 0);

    // "-512 " : one result, visible the cycle after the space, for exactly one cycle
    clear_mon();
    send_str("-512 ");
    idle(4);
    check("neg512_size", q.size(), 1);
    check_res("neg512", 10'd512, 1'b1, 1'b0, 2'd0);
    check("neg512_latency", first_valid, last_acc);
    check("neg512_width", valid_cycles, 1);

    // upper bound of W=10 and one past it
    clear_mon();
    send_str("1023\n");
    send_str("1024\n");
    idle(4);
    check("bound_size", q.size(), 2);
    check_res("max_1023", 10'd1023, 1'b0, 1'b0, 2'd0);
    check_res("ovf_1024", 10'd0, 1'b0, 1'b1, 2'd2);

    // bad char, bare sign, too many digits with leading zeros
    clear_mon();
    send_str("12a4,");
    send_str("- ");
    send_str("+00001 ");
    idle(4);
    check("err_size", q.size(), 3);
    check_res("bad_char", 10'd0, 1'b0, 1'b1, 2'd1);
    check_res("bare_sign", 10'd0, 1'b0, 1'b1, 2'd3);
    check_res("five_digits", 10'd0, 1'b0, 1'b1, 2'd2);

    // "7 8 " with back-pressure for five cycles after the first result
    clear_mon();
    bus.out_ready = 1'b0;
    send_str("7 ");
    fork
      send_str("8 ");
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("hold_valid", bus.out_valid, 1);
          check("hold_num", bus.num, 7);
          check("hold_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    idle(4);
    check("bp_size", q.size(), 2);
    check_res("bp_first", 10'd7, 1'b0, 1'b0, 2'd0);
    check_res("bp_second", 10'd8, 1'b0, 1'b0, 2'd0);

    // delimiters only: no result, never stalls
    clear_mon();
    send_str("  ,\r\n");
    idle(4);
    check("delim_no_result", valid_cycles, 0);
    check("delim_ready", ready_low, 0);

    // "-0" keeps its sign
    clear_mon();
    send_str("-0 ");
    idle(4);
    check_res("neg_zero", 10'd0, 1'b1, 1'b0, 2'd0);

    // reset in the middle of a token drops it
    clear_mon();
    send_str("98");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_outputs", {bus.num, bus.neg, bus.err, bus.err_code}, 0);
    send_str("3 ");
    idle(4);
    check("rst_tok_size", q.size(), 1);
    check_res("after_rst", 10'd3, 1'b0, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/char2num.md
Name: char2num

Overview:
- Parses a serial stream of ASCII bytes into a signed decimal value; the inverse of the team's number-to-ASCII formatter.
- Intended for UART/console input paths that feed numeric settings, e.g. the seg display value or thresholds.
- Accepts one byte per cycle on a valid/ready handshake.
- Each delimiter-terminated token yields one result: magnitude, sign flag, error code.

Parameters:
W, 10, magnitude width in bits; legal values 0..2^W-1
MAX_DIGITS, 4, maximum digit count per token, leading zeros included

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
in_data  input  8  ASCII byte
in_valid  input  1  in_data valid
in_ready  output  1  byte accepted when in_valid && in_ready
out_valid  output  1  result available; held until accepted
out_ready  input  1  result consumed when out_valid && out_ready
num  output  W  parsed magnitude
neg  output  1  token had a leading '-'
err  output  1  token was malformed
err_code  output  2  0 none, 1 bad character, 2 overflow, 3 sign without digits

Behaviour:
- Character classes:
  - digit: 0x30..0x39
  - sign: '-' 0x2D, '+' 0x2B
  - delimiter: space 0x20, CR 0x0D, LF 0x0A, ',' 0x2C
  - anything else is "other".
- Reset (rst high at a clk edge), values after that edge:
  - state=IDLE, acc=0, cnt=0, neg_r=0, code_r=0
  - out_valid=0, num=0, neg=0, err=0, err_code=0, in_ready=1.
  - Reset mid-token discards the partial token; no result is emitted.
- in_ready = !out_valid (registered out_valid). No byte is accepted while a result is pending.
- Bytes are processed only on accept (in_valid && in_ready); otherwise all state holds.
- IDLE:
  - delimiter: ignored, stay.
  - '-': neg_r=1, go SIGN.
  - '+': neg_r=0, go SIGN.
  - digit: acc=d, cnt=1, neg_r=0, go DIGIT.
  - other: code_r=1, go FLUSH.
- SIGN:
  - digit: acc=d, cnt=1, go DIGIT.
  - delimiter: emit error code 3, go IDLE.
  - sign or other: code_r=1, go FLUSH.
- DIGIT:
  - digit, cnt==MAX_DIGITS: code_r=2, go FLUSH.
  - digit, acc*10+d > 2^W-1: code_r=2, go FLUSH.
  - digit, otherwise: acc=acc*10+d, cnt=cnt+1.
  - Compute acc*10+d at W+4 bits, as (acc<<3)+(acc<<1)+d, before the compare. No truncation.
  - delimiter: emit success (num=acc, neg=neg_r, err=0, code 0), go IDLE.
  - sign or other: code_r=1, go FLUSH.
- FLUSH:
  - Discard all non-delimiter bytes.
  - code_r keeps the first error only.
  - delimiter: emit error with code_r, go IDLE.
- Emit rules:
  - The result registers load on the clk edge that accepts the delimiter; out_valid=1 from the next cycle (1-cycle latency).
  - On any error result: num=0, neg=0, err=1.
  - After emit: acc, cnt, neg_r, code_r clear.
- Output hold: num, neg, err, err_code and out_valid are stable while out_valid && !out_ready.
- Output clear: out_valid clears on the edge where out_valid && out_ready. in_ready rises the following cycle.
- Zero-length tokens (consecutive delimiters) produce no result.
- "-0" gives num=0, neg=1, err=0; the sign is reported verbatim.
- Leading zeros count toward MAX_DIGITS: "0001" is legal, "00001" is overflow (code 2).

Test Plan:
- Send "-512 " with out_ready=1 -> one result: num=512, neg=1, err=0, err_code=0; out_valid high exactly 1 cycle, 1 cycle after the space is accepted.
- Send "1023\n" then "1024\n" -> first: num=1023, err=0. Second: err=1, err_code=2, num=0.
- Send "12a4,", then "- ", then "+00001 " -> err_code=1, then err_code=3, then err_code=2; exactly 3 results, no result for the extra spaces.
- Send "7 8 " with out_ready=0 for 5 cycles after the first result -> out_valid=1 and num=7 held 5 cycles, in_ready=0 throughout. After out_ready=1: num=8 delivered, no byte lost.
- Send "  ,\r\n" -> no result; in_ready stays 1.
- Send "98" then assert rst 1 cycle, then "3 " -> only one result, num=3, neg=0. All outputs 0 and in_ready=1 the cycle after reset.
